// File: rtl/spi_slave_port.sv
// Mode-0 SPI slave (CPOL=0, CPHA=0) oversampled in the clk_i domain, full duplex, WIDTH-bit frames.
// Latency: inputs reach edge detect after SYNC_STAGES+1 cycles; rx_valid_o one cycle after the last detected sclk rise.
// Backpressure: one-entry tx buffer (tx_ready_o = buffer empty); rx words are a fire-and-forget pulse.
//
// Ports: clk_i/rst_i (sync, active-high); sclk_i/cs_n_i/mosi_i async SPI inputs; miso_o;
//        tx_data_i/tx_valid_i/tx_ready_o transmit handshake; rx_data_o/rx_valid_o received word;
//        tx_underrun_o pulses when a frame starts with an empty buffer.
// Build option: define SPI_SLAVE_LSB_FIRST_EN to shift both directions LSB-first (default MSB-first).
module spi_slave_port #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sclk_i,
    input  logic             cs_n_i,
    input  logic             mosi_i,
    output logic             miso_o,
    input  logic [WIDTH-1:0] tx_data_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    output logic [WIDTH-1:0] rx_data_o,
    output logic             rx_valid_o,
    output logic             tx_underrun_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT
    } state_t;

    // Synchronizers plus one extra registered copy for edge detection.
    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
            cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = ~cs_s & cs_prev_q;

    state_t           state_q, state_d;
    logic             defer_q, defer_d;      // LOAD must wait for the sclk fall that ends the previous frame
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             und_q, und_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             full_q, full_d;

    logic             load_go;
    logic             tx_accept;
    logic [WIDTH-1:0] rx_next, tx_next;
    logic             tx_bit;

`ifdef SPI_SLAVE_LSB_FIRST_EN
    assign rx_next = {mosi_s, rx_sh_q[WIDTH-1:1]};
    assign tx_next = {1'b0, tx_sh_q[WIDTH-1:1]};
    assign tx_bit  = tx_sh_q[0];
`else
    assign rx_next = {rx_sh_q[WIDTH-2:0], mosi_s};
    assign tx_next = {tx_sh_q[WIDTH-2:0], 1'b0};
    assign tx_bit  = tx_sh_q[WIDTH-1];
`endif

    always_comb begin
        state_d    = state_q;
        defer_d    = defer_q;
        cnt_d      = cnt_q;
        rx_sh_d    = rx_sh_q;
        tx_sh_d    = tx_sh_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        und_d      = 1'b0;
        load_go    = 1'b0;

        if (cs_rise) begin
            // Abort: partial rx word and any loaded tx word are dropped.
            state_d = ST_IDLE;
            defer_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (cs_fall) begin
                        state_d = ST_LOAD;
                        defer_d = 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (!defer_q || sclk_fall) begin
                        load_go = 1'b1;
                        tx_sh_d = full_q ? buf_q : '0;
                        und_d   = ~full_q;
                        rx_sh_d = '0;
                        cnt_d   = '0;
                        state_d = ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (sclk_rise) begin
                        rx_sh_d = rx_next;
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == LAST_BIT) begin
                            rx_data_d  = rx_next;
                            rx_valid_d = 1'b1;
                            state_d    = ST_LOAD;
                            defer_d    = 1'b1;
                        end
                    end else if (sclk_fall) begin
                        tx_sh_d = tx_next;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // LOAD sees the old full flag, so a same-cycle write only lands in an empty buffer and waits for the next frame.
    assign tx_accept = tx_valid_i & ~full_q;
    assign full_d    = tx_accept | (full_q & ~load_go);
    assign buf_d     = tx_accept ? tx_data_i : buf_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            defer_q    <= 1'b0;
            cnt_q      <= '0;
            rx_sh_q    <= '0;
            tx_sh_q    <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            und_q      <= 1'b0;
            buf_q      <= '0;
            full_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            defer_q    <= defer_d;
            cnt_q      <= cnt_d;
            rx_sh_q    <= rx_sh_d;
            tx_sh_q    <= tx_sh_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            und_q      <= und_d;
            buf_q      <= buf_d;
            full_q     <= full_d;
        end
    end

    assign miso_o        = ~cs_s & tx_bit;
    assign tx_ready_o    = ~full_q;
    assign rx_data_o     = rx_data_q;
    assign rx_valid_o    = rx_valid_q;
    assign tx_underrun_o = und_q;

endmodule

// File: tb/tb_spi_slave_port.sv
// Testbench for spi_slave_port: SPI master at SCLK = clk/8, table vectors, hand sequences, random frames vs a buffer model.
// Latency: frames take about 90 clk cycles each.
// Backpressure: writes only where the model says the buffer state is known.
module tb_spi_slave_port;

    localparam int W = 8;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b1;
    logic         sclk_i = 1'b0;
    logic         cs_n_i = 1'b1;
    logic         mosi_i = 1'b0;
    logic         miso_o;
    logic [W-1:0] tx_data_i = '0;
    logic         tx_valid_i = 1'b0;
    logic         tx_ready_o;
    logic [W-1:0] rx_data_o;
    logic         rx_valid_o;
    logic         tx_underrun_o;

    always #5 clk_i = ~clk_i;

    spi_slave_port #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .sclk_i        (sclk_i),
        .cs_n_i        (cs_n_i),
        .mosi_i        (mosi_i),
        .miso_o        (miso_o),
        .tx_data_i     (tx_data_i),
        .tx_valid_i    (tx_valid_i),
        .tx_ready_o    (tx_ready_o),
        .rx_data_o     (rx_data_o),
        .rx_valid_o    (rx_valid_o),
        .tx_underrun_o (tx_underrun_o)
    );

    int checks = 0;
    int errors = 0;

    // Monitor: every rx_valid pulse and underrun pulse, sampled mid-cycle.
    logic [W-1:0] rx_seen[$];
    int           und_cnt = 0;

    always @(negedge clk_i) begin
        if (rx_valid_o) rx_seen.push_back(rx_data_o);
        if (tx_underrun_o) und_cnt++;
    end

    // Reference model: one-entry buffer and the last completed rx word.
    bit           m_full = 1'b0;
    logic [W-1:0] m_buf  = '0;
    logic [W-1:0] m_last = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    function automatic int bit_idx(input int i);
`ifdef SPI_SLAVE_LSB_FIRST_EN
        return i;
`else
        return W - 1 - i;
`endif
    endfunction

    task automatic wr(input logic [W-1:0] d);
        tx_data_i  = d;
        tx_valid_i = 1'b1;
        wait_n(1);
        tx_valid_i = 1'b0;
    endtask

    // Master shifts nbits; with close set, cs_n rises while sclk is still high after the last bit.
    task automatic xfer(input logic [W-1:0] m, input int nbits, input bit close,
                        output logic [W-1:0] got, output logic first);
        got   = '0;
        first = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            int b;
            b = bit_idx(i);
            mosi_i = m[b];
            wait_n(4);
            sclk_i = 1'b1;
            got[b] = miso_o;
            if (i == 0) first = miso_o;
            wait_n(4);
            if (close && i == nbits - 1) begin
                cs_n_i = 1'b1;
                wait_n(4);
            end
            sclk_i = 1'b0;
        end
        if (close) wait_n(8);
    endtask

    task automatic open_frame();
        rx_seen.delete();
        und_cnt = 0;
        cs_n_i  = 1'b0;
        wait_n(6);
    endtask

    task automatic model_write(input logic [W-1:0] d, input string tag);
        chk($sformatf("%s tx_ready", tag), tx_ready_o, !m_full);
        wr(d);
        if (!m_full) begin
            m_full = 1'b1;
            m_buf  = d;
        end
    endtask

    task automatic model_frame(input logic [W-1:0] m, input int nbits, input string tag);
        logic [W-1:0] exp_miso, got;
        int           exp_und;
        logic         first;
        exp_miso = m_full ? m_buf : '0;
        exp_und  = m_full ? 0 : 1;
        m_full   = 1'b0;
        open_frame();
        chk($sformatf("%s ready_after_load", tag), tx_ready_o, 1);
        xfer(m, nbits, 1'b1, got, first);
        if (nbits == W) begin
            chk($sformatf("%s miso_word", tag), got, exp_miso);
            chk($sformatf("%s rx_count", tag), rx_seen.size(), 1);
            chk($sformatf("%s rx_data", tag), rx_data_o, m);
            m_last = m;
        end else begin
            chk($sformatf("%s abort_rx_count", tag), rx_seen.size(), 0);
            chk($sformatf("%s abort_rx_data", tag), rx_data_o, m_last);
        end
        chk($sformatf("%s underrun", tag), und_cnt, exp_und);
    endtask

    typedef struct {
        int           nwr;
        logic [W-1:0] tx0;
        logic [W-1:0] tx1;
        logic [W-1:0] mosi;
        logic [W-1:0] exp_miso;
        logic [W-1:0] exp_rx;
        int           exp_und;
    } vec_t;

    initial begin
        vec_t         vecs[5];
        logic [W-1:0] g1, g2, got;
        logic         f1, first;
        logic [W-1:0] q0, q1;

        vecs[0] = '{1, 8'hA5, 8'h00, 8'h3C, 8'hA5, 8'h3C, 0};
        vecs[1] = '{0, 8'h00, 8'h00, 8'h55, 8'h00, 8'h55, 1};
        vecs[2] = '{2, 8'h12, 8'h34, 8'hC3, 8'h12, 8'hC3, 0};  // second write refused: buffer full
        vecs[3] = '{1, 8'h01, 8'h00, 8'h80, 8'h01, 8'h80, 0};
        vecs[4] = '{1, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 0};

        // Reset state
        wait_n(2);
        chk("rst miso", miso_o, 0);
        chk("rst tx_ready", tx_ready_o, 1);
        chk("rst rx_data", rx_data_o, 0);
        chk("rst rx_valid", rx_valid_o, 0);
        chk("rst underrun", tx_underrun_o, 0);
        rst_i = 1'b0;
        wait_n(4);
        chk("idle tx_ready", tx_ready_o, 1);
        chk("idle miso", miso_o, 0);

        // Table-driven frames
        for (int v = 0; v < 5; v++) begin
            if (vecs[v].nwr >= 1) model_write(vecs[v].tx0, $sformatf("vec%0d w0", v));
            if (vecs[v].nwr >= 2) model_write(vecs[v].tx1, $sformatf("vec%0d w1", v));
            open_frame();
            chk($sformatf("vec%0d ready_after_load", v), tx_ready_o, 1);
            xfer(vecs[v].mosi, W, 1'b1, got, first);
            chk($sformatf("vec%0d miso_word", v), got, vecs[v].exp_miso);
            chk($sformatf("vec%0d first_bit", v), first, vecs[v].exp_miso[bit_idx(0)]);
            chk($sformatf("vec%0d rx_count", v), rx_seen.size(), 1);
            chk($sformatf("vec%0d rx_data", v), rx_data_o, vecs[v].exp_rx);
            chk($sformatf("vec%0d underrun", v), und_cnt, vecs[v].exp_und);
            m_full = 1'b0;
            m_last = vecs[v].exp_rx;
        end

        // Back-to-back frames with cs_n held low, refilled during frame 1
        model_write(8'h11, "b2b w0");
        open_frame();
        chk("b2b ready_after_load", tx_ready_o, 1);
        wr(8'h22);
        xfer(8'hF0, W, 1'b0, g1, f1);
        xfer(8'h0F, W, 1'b1, g2, f1);
        q0 = (rx_seen.size() > 0) ? rx_seen[0] : 'x;
        q1 = (rx_seen.size() > 1) ? rx_seen[1] : 'x;
        chk("b2b miso_word1", g1, 8'h11);
        chk("b2b miso_word2", g2, 8'h22);
        chk("b2b rx_count", rx_seen.size(), 2);
        chk("b2b rx_word1", q0, 8'hF0);
        chk("b2b rx_word2", q1, 8'h0F);
        chk("b2b underrun", und_cnt, 0);
        m_full = 1'b0;
        m_last = 8'h0F;

        // Abort after 5 bits with an empty buffer, then a clean frame
        model_frame(8'hB7, 5, "abort");
        model_write(8'h96, "post_abort w0");
        model_frame(8'h81, W, "post_abort");

        // Reset in the middle of a frame with a refilled buffer
        model_write(8'h77, "rstmid w0");
        open_frame();
        wr(8'h5A);
        xfer(8'hC3, 3, 1'b0, got, first);
        rst_i  = 1'b1;
        cs_n_i = 1'b1;
        sclk_i = 1'b0;
        mosi_i = 1'b0;
        wait_n(2);
        chk("rstmid tx_ready", tx_ready_o, 1);
        chk("rstmid rx_data", rx_data_o, 0);
        chk("rstmid miso", miso_o, 0);
        rst_i = 1'b0;
        wait_n(6);
        chk("rstmid rx_count", rx_seen.size(), 0);
        m_full = 1'b0;
        m_last = '0;
        model_frame(8'hE1, W, "post_rst");

        // Random frames against the model, including refused writes and aborts
        for (int r = 0; r < 14; r++) begin
            int nwr, nb;
            nwr = $urandom_range(0, 2);
            for (int k = 0; k < nwr; k++) model_write(W'($urandom), $sformatf("rnd%0d w%0d", r, k));
            nb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, W - 1) : W;
            model_frame(W'($urandom), nb, $sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_port.md
# spi_slave_port

Mode-0 SPI slave (CPOL=0, CPHA=0) running entirely in the system clock domain. It oversamples an external SCLK/CS_N/MOSI from a master whose SCLK comes from the clock divider, and performs full-duplex byte transfers. Received words go out on a valid pulse. Transmit words come from a one-entry buffer with a ready/valid handshake. It is the responder end of the SPI link.

## Interface
- WIDTH, 8: bits per frame word.
- SYNC_STAGES, 2: flip-flop stages on each asynchronous input (legal values 2–3).

- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- sclk  in  1  SPI serial clock from the master, asynchronous to clk.
- cs_n  in  1  active-low chip select, asynchronous.
- mosi  in  1  master-out data, asynchronous.
- miso  out  1  slave-out data.
- tx_data  in  WIDTH  word to send in the next frame.
- tx_valid  in  1  tx_data is valid.
- tx_ready  out  1  the transmit buffer is empty and can accept a word.
- rx_data  out  WIDTH  last complete received word.
- rx_valid  out  1  one-cycle pulse when rx_data updates.
- tx_underrun  out  1  one-cycle pulse when a frame starts with an empty buffer.

## Operation
- Input sync: sclk, cs_n and mosi each pass through SYNC_STAGES flops. One more registered copy gives edge detection.
  - sclk_rise = sync high and previous low.
  - sclk_fall = sync high-to-low.
  - cs_fall / cs_rise are defined the same way.
- Transmit buffer: one WIDTH register plus a full flag.
  - Accept a word when tx_valid && tx_ready. tx_ready = !full.
  - The buffer is consumed (full cleared) at word load, see LOAD.
- FSM states:
  - IDLE: wait for cs_fall, then go to LOAD.
  - LOAD: one cycle.
    - Shift-out register ← buffer if full, else all zeros with a tx_underrun pulse.
    - Clear full. bit_cnt ← 0. Go to SHIFT.
  - SHIFT, on sclk_rise:
    - rx shift register takes the synchronized mosi.
    - bit_cnt increments.
    - When bit_cnt reaches WIDTH−1: rx_data ← assembled word, pulse rx_valid, go to LOAD. LOAD runs only on the next sclk_fall, so back-to-back frames need no CS toggle.
  - SHIFT, on sclk_fall (not after the last bit): shift-out register advances one bit.
  - Any state, on cs_rise: go to IDLE.
    - The partial rx word is discarded and there is no rx_valid.
    - A word already moved into the shift-out register is lost. A word still in the buffer is kept.
- miso shows the current MSB of the shift-out register while cs_n (synchronized) is low. It is 0 otherwise.
- Simultaneous tx_valid write and LOAD consume in the same cycle: LOAD takes the old buffer state. The new word is accepted only if the buffer was not full, and it then stays for the next frame.

## Timing
- Reset values:
  - miso = 0, tx_ready = 1, rx_data = 0, rx_valid = 0, tx_underrun = 0.
  - FSM = IDLE, buffer empty.
  - Sync flops = 1 for cs_n and 0 for sclk and mosi.
- Reset asserted mid-frame aborts the frame immediately. It gives no rx_valid and empties the buffer.
- Input-to-edge-detect latency is SYNC_STAGES+1 clk cycles.
- rx_valid asserts 1 cycle after the detected 8th (WIDTH-th) sclk_rise.
- The first miso bit is valid SYNC_STAGES+2 cycles after cs_n falls.
- The master must keep each SCLK phase at least SYNC_STAGES+2 clk cycles long. The divider's default ÷8 with SYNC_STAGES=2 is compliant.
- mosi must be stable for SYNC_STAGES+1 cycles around the SCLK rising edge.

## Configuration
- SPI_SLAVE_LSB_FIRST_EN defined: both shift registers run LSB-first. miso shows bit 0, and received bits enter at the MSB and shift right.
- Undefined (default): MSB-first in both directions.

## Test plan
- Reset, then idle: rst high 2 cycles → all outputs at their reset values. tx_ready=1 and miso=0 with cs_n=1.
- Single frame: write tx 0xA5, master sends 0x3C at SCLK=clk/8 → rx_data=0x3C with one rx_valid pulse. Master captures 0xA5. tx_ready goes back to 1 at LOAD.
- Back-to-back: buffer 0x11, then refill with 0x22 during frame 1; master sends 0xF0, 0x0F with cs_n held low → two rx_valid pulses (0xF0, 0x0F). miso carries 0x11 then 0x22.
- Underrun: no tx write, frame 0x55 → tx_underrun pulses once. Master receives 0x00 and rx_data=0x55.
- Abort: cs_n rises after 5 bits → no rx_valid, rx_data keeps its previous value. The next full frame 0x81 is received correctly.
- LSB mode (macro defined): tx 0x01, master sends 0x80 → the first miso bit is 1 and rx_data=0x80.
